// File: rtl/ctrl_pkg.sv
// Shared opcode map, write-back select encoding and packed control bundles
// for the RV32I control pipeline.
package ctrl_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_OP_BRANCH = 4'b1000;

  typedef enum logic [1:0] {
    M2R_ALU  = 2'b00,
    M2R_IMM  = 2'b01,
    M2R_PC4  = 2'b10,
    M2R_LOAD = 2'b11
  } m2r_e;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    m2r_e m2r;
  } wb_ctrl_t;

  // Only R-type, store and branch instructions actually read rs2.
  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational decode of the ID-stage opcode/funct3 into control bits.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W = 4,
  parameter bit          CSR_EN   = 1'b1
) (
  input  logic [6:0]          i_op_code,
  input  logic [2:0]          i_funct3,
  output logic                o_alu_src_b,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic                o_branch,
  output logic                o_b_type,
  output mem_ctrl_t           o_mem,
  output wb_ctrl_t            o_wb,
  output logic                o_illegal
);

  always_comb begin
    o_alu_src_b = 1'b0;
    o_alu_op    = '0;
    o_branch    = 1'b0;
    o_b_type    = 1'b0;
    o_mem       = '0;
    o_wb        = '0;
    o_illegal   = 1'b0;
    case (i_op_code)
      OPC_OP_IMM, OPC_OP: begin
        o_wb.reg_write = 1'b1;
        o_alu_src_b    = ~i_op_code[5];
        o_alu_op       = ALU_OP_W'(i_funct3);
      end
      OPC_LOAD: begin
        o_wb.reg_write = 1'b1;
        o_wb.m2r       = M2R_LOAD;
        o_alu_src_b    = 1'b1;
        o_mem.mem_read = 1'b1;
      end
      OPC_STORE: begin
        o_alu_src_b     = 1'b1;
        o_mem.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        o_branch = 1'b1;
        o_b_type = (i_funct3 == 3'b000);
        o_alu_op = ALU_OP_W'(ALU_OP_BRANCH);
      end
      OPC_LUI: begin
        o_wb.reg_write = 1'b1;
        o_wb.m2r       = M2R_IMM;
        o_alu_src_b    = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        o_wb.reg_write = 1'b1;
        o_wb.m2r       = M2R_PC4;
        o_alu_src_b    = ~i_op_code[3];
      end
      OPC_AUIPC: begin
        o_wb.reg_write = 1'b1;
        o_alu_src_b    = 1'b1;
      end
      OPC_SYSTEM: begin
        o_wb.reg_write = CSR_EN;
        o_illegal      = ~CSR_EN;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// RV32I control path: ID decode staged through ID/EX, EX/MEM, MEM/WB with
// load-use stall, redirect flush and external stall handling.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W = 4,
  parameter int unsigned RA_W     = 5,
  parameter bit          CSR_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          op_code,
  input  logic [2:0]          funct3,
  input  logic                funct7_5,
  input  logic [RA_W-1:0]     rs1,
  input  logic [RA_W-1:0]     rs2,
  input  logic [RA_W-1:0]     rd,
  input  logic                stall_ext,
  input  logic                ex_redirect,
  output logic                ex_alu_src_b,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_funct7_5,
  output logic                ex_branch,
  output logic                ex_b_type,
  output logic [RA_W-1:0]     ex_rd,
  output logic                mem_mem_write,
  output logic [RA_W-1:0]     mem_rd,
  output logic                mem_reg_write,
  output logic                wb_reg_write,
  output logic [1:0]          wb_mem_to_reg,
  output logic [RA_W-1:0]     wb_rd,
  output logic                pc_stall,
  output logic                ifid_stall,
  output logic                ifid_flush,
  output logic                ex_illegal
);

  logic                w_alu_src_b;
  logic [ALU_OP_W-1:0] w_alu_op;
  logic                w_branch;
  logic                w_b_type;
  logic                w_illegal;
  mem_ctrl_t           w_mem;
  wb_ctrl_t            w_wb;
  logic                w_load_use;
  logic                w_id_bubble;

  logic                r_ex_alu_src_b;
  logic [ALU_OP_W-1:0] r_ex_alu_op;
  logic                r_ex_funct7_5;
  logic                r_ex_branch;
  logic                r_ex_b_type;
  logic [RA_W-1:0]     r_ex_rd;
  mem_ctrl_t           r_ex_mem;
  wb_ctrl_t            r_ex_wb;
  logic                r_ex_illegal;
  logic                r_mem_mem_write;
  wb_ctrl_t            r_mem_wb;
  logic [RA_W-1:0]     r_mem_rd;
  wb_ctrl_t            r_wb_wb;
  logic [RA_W-1:0]     r_wb_rd;

  ctrl_decode #(
    .ALU_OP_W (ALU_OP_W),
    .CSR_EN   (CSR_EN)
  ) u_decode (
    .i_op_code   (op_code),
    .i_funct3    (funct3),
    .o_alu_src_b (w_alu_src_b),
    .o_alu_op    (w_alu_op),
    .o_branch    (w_branch),
    .o_b_type    (w_b_type),
    .o_mem       (w_mem),
    .o_wb        (w_wb),
    .o_illegal   (w_illegal)
  );

  assign w_load_use  = r_ex_mem.mem_read && (r_ex_rd != '0) &&
                       ((r_ex_rd == rs1) || ((r_ex_rd == rs2) && uses_rs2(op_code)));
  assign w_id_bubble = ex_redirect || w_load_use;

  // Gated by rst_n so hazard outputs are also 0 while reset is held.
  assign pc_stall   = rst_n && (stall_ext || (!ex_redirect && w_load_use));
  assign ifid_stall = pc_stall;
  assign ifid_flush = rst_n && !stall_ext && ex_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_alu_src_b  <= 1'b0;
      r_ex_alu_op     <= '0;
      r_ex_funct7_5   <= 1'b0;
      r_ex_branch     <= 1'b0;
      r_ex_b_type     <= 1'b0;
      r_ex_rd         <= '0;
      r_ex_mem        <= '0;
      r_ex_wb         <= '0;
      r_ex_illegal    <= 1'b0;
      r_mem_mem_write <= 1'b0;
      r_mem_wb        <= '0;
      r_mem_rd        <= '0;
      r_wb_wb         <= '0;
      r_wb_rd         <= '0;
    end else if (!stall_ext) begin
      if (w_id_bubble) begin
        r_ex_alu_src_b <= 1'b0;
        r_ex_alu_op    <= '0;
        r_ex_funct7_5  <= 1'b0;
        r_ex_branch    <= 1'b0;
        r_ex_b_type    <= 1'b0;
        r_ex_rd        <= '0;
        r_ex_mem       <= '0;
        r_ex_wb        <= '0;
        r_ex_illegal   <= 1'b0;
      end else begin
        r_ex_alu_src_b <= w_alu_src_b;
        r_ex_alu_op    <= w_alu_op;
        r_ex_funct7_5  <= funct7_5 & ~w_illegal;
        r_ex_branch    <= w_branch;
        r_ex_b_type    <= w_b_type;
        // rd is only meaningful for writers; store/branch rd bits are immediate.
        r_ex_rd        <= w_wb.reg_write ? rd : '0;
        r_ex_mem       <= w_mem;
        r_ex_wb        <= w_wb;
        r_ex_illegal   <= w_illegal;
      end
      r_mem_mem_write <= r_ex_mem.mem_write;
      r_mem_wb        <= r_ex_wb;
      r_mem_rd        <= r_ex_rd;
      r_wb_wb         <= r_mem_wb;
      r_wb_rd         <= r_mem_rd;
    end
  end

  assign ex_alu_src_b  = r_ex_alu_src_b;
  assign ex_alu_op     = r_ex_alu_op;
  assign ex_funct7_5   = r_ex_funct7_5;
  assign ex_branch     = r_ex_branch;
  assign ex_b_type     = r_ex_b_type;
  assign ex_rd         = r_ex_rd;
  assign ex_illegal    = r_ex_illegal;
  assign mem_mem_write = r_mem_mem_write;
  assign mem_rd        = r_mem_rd;
  assign mem_reg_write = r_mem_wb.reg_write;
  assign wb_reg_write  = r_wb_wb.reg_write && (r_wb_rd != '0);
  assign wb_mem_to_reg = r_wb_wb.m2r;
  assign wb_rd         = r_wb_rd;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Randomized + directed check of ctrl_pipeline (CSR_EN=1 and CSR_EN=0 instances)
// against a stage-array reference model.
module tb_ctrl_pipeline;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op_code;
  logic [2:0] funct3;
  logic       funct7_5;
  logic [4:0] rs1, rs2, rd;
  logic       stall_ext, ex_redirect;

  logic       ex_alu_src_b  [2];
  logic [3:0] ex_alu_op     [2];
  logic       ex_funct7_5   [2];
  logic       ex_branch     [2];
  logic       ex_b_type     [2];
  logic [4:0] ex_rd         [2];
  logic       mem_mem_write [2];
  logic [4:0] mem_rd        [2];
  logic       mem_reg_write [2];
  logic       wb_reg_write  [2];
  logic [1:0] wb_mem_to_reg [2];
  logic [4:0] wb_rd         [2];
  logic       pc_stall      [2];
  logic       ifid_stall    [2];
  logic       ifid_flush    [2];
  logic       ex_illegal    [2];

  always #5 clk = ~clk;

  ctrl_pipeline #(.ALU_OP_W(4), .RA_W(5), .CSR_EN(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .funct3(funct3), .funct7_5(funct7_5),
    .rs1(rs1), .rs2(rs2), .rd(rd), .stall_ext(stall_ext), .ex_redirect(ex_redirect),
    .ex_alu_src_b(ex_alu_src_b[0]), .ex_alu_op(ex_alu_op[0]), .ex_funct7_5(ex_funct7_5[0]),
    .ex_branch(ex_branch[0]), .ex_b_type(ex_b_type[0]), .ex_rd(ex_rd[0]),
    .mem_mem_write(mem_mem_write[0]), .mem_rd(mem_rd[0]), .mem_reg_write(mem_reg_write[0]),
    .wb_reg_write(wb_reg_write[0]), .wb_mem_to_reg(wb_mem_to_reg[0]), .wb_rd(wb_rd[0]),
    .pc_stall(pc_stall[0]), .ifid_stall(ifid_stall[0]), .ifid_flush(ifid_flush[0]),
    .ex_illegal(ex_illegal[0])
  );

  ctrl_pipeline #(.ALU_OP_W(4), .RA_W(5), .CSR_EN(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .funct3(funct3), .funct7_5(funct7_5),
    .rs1(rs1), .rs2(rs2), .rd(rd), .stall_ext(stall_ext), .ex_redirect(ex_redirect),
    .ex_alu_src_b(ex_alu_src_b[1]), .ex_alu_op(ex_alu_op[1]), .ex_funct7_5(ex_funct7_5[1]),
    .ex_branch(ex_branch[1]), .ex_b_type(ex_b_type[1]), .ex_rd(ex_rd[1]),
    .mem_mem_write(mem_mem_write[1]), .mem_rd(mem_rd[1]), .mem_reg_write(mem_reg_write[1]),
    .wb_reg_write(wb_reg_write[1]), .wb_mem_to_reg(wb_mem_to_reg[1]), .wb_rd(wb_rd[1]),
    .pc_stall(pc_stall[1]), .ifid_stall(ifid_stall[1]), .ifid_flush(ifid_flush[1]),
    .ex_illegal(ex_illegal[1])
  );

  typedef struct packed {
    logic       sb;
    logic [3:0] op;
    logic       f7;
    logic       br;
    logic       bt;
    logic [4:0] rd;
    logic       mr;
    logic       mw;
    logic       rw;
    logic [1:0] m2r;
    logic       ill;
  } ctl_t;

  // st[k][0]=EX, [1]=MEM, [2]=WB for instance k
  ctl_t st [2][3];
  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic ctl_t ref_decode(input logic [6:0] opc, input logic [2:0] f3,
                                      input logic f7, input logic [4:0] d, input bit csr);
    ctl_t c = '0;
    case (opc)
      7'b0010011: begin c.rw = 1; c.sb = 1; c.op = {1'b0, f3}; end
      7'b0110011: begin c.rw = 1; c.op = {1'b0, f3}; end
      7'b0000011: begin c.rw = 1; c.sb = 1; c.m2r = 2'b11; c.mr = 1; end
      7'b0100011: begin c.sb = 1; c.mw = 1; end
      7'b1100011: begin c.br = 1; c.bt = (f3 == 3'b000); c.op = 4'b1000; end
      7'b0110111: begin c.rw = 1; c.sb = 1; c.m2r = 2'b01; end
      7'b1101111: begin c.rw = 1; c.m2r = 2'b10; end
      7'b1100111: begin c.rw = 1; c.sb = 1; c.m2r = 2'b10; end
      7'b0010111: begin c.rw = 1; c.sb = 1; end
      7'b1110011: begin if (csr) c.rw = 1; else c.ill = 1; end
      default:    c.ill = 1;
    endcase
    if (!c.ill) c.f7 = f7;
    if (c.rw) c.rd = d;
    return c;
  endfunction

  function automatic bit ref_load_use(input ctl_t e);
    bit reads_rs2 = (op_code == 7'b0110011) || (op_code == 7'b0100011) || (op_code == 7'b1100011);
    return e.mr && (e.rd != 0) && ((e.rd == rs1) || ((e.rd == rs2) && reads_rs2));
  endfunction

  task automatic check_all(input int unsigned k);
    ctl_t e = st[k][0];
    ctl_t m = st[k][1];
    ctl_t w = st[k][2];
    bit   lu = ref_load_use(e);
    bit   stl = stall_ext || (!ex_redirect && lu);
    expect_eq($sformatf("u%0d.ex_src_b", k),  32'(ex_alu_src_b[k]),  32'(e.sb));
    expect_eq($sformatf("u%0d.ex_op", k),     32'(ex_alu_op[k]),     32'(e.op));
    expect_eq($sformatf("u%0d.ex_f7", k),     32'(ex_funct7_5[k]),   32'(e.f7));
    expect_eq($sformatf("u%0d.ex_br", k),     32'(ex_branch[k]),     32'(e.br));
    expect_eq($sformatf("u%0d.ex_bt", k),     32'(ex_b_type[k]),     32'(e.bt));
    expect_eq($sformatf("u%0d.ex_rd", k),     32'(ex_rd[k]),         32'(e.rd));
    expect_eq($sformatf("u%0d.ex_ill", k),    32'(ex_illegal[k]),    32'(e.ill));
    expect_eq($sformatf("u%0d.mem_mw", k),    32'(mem_mem_write[k]), 32'(m.mw));
    expect_eq($sformatf("u%0d.mem_rd", k),    32'(mem_rd[k]),        32'(m.rd));
    expect_eq($sformatf("u%0d.mem_rw", k),    32'(mem_reg_write[k]), 32'(m.rw));
    expect_eq($sformatf("u%0d.wb_rw", k),     32'(wb_reg_write[k]),  32'(w.rw && (w.rd != 0)));
    expect_eq($sformatf("u%0d.wb_m2r", k),    32'(wb_mem_to_reg[k]), 32'(w.m2r));
    expect_eq($sformatf("u%0d.wb_rd", k),     32'(wb_rd[k]),         32'(w.rd));
    expect_eq($sformatf("u%0d.pc_stall", k),  32'(pc_stall[k]),      32'(stl));
    expect_eq($sformatf("u%0d.ifid_stall", k), 32'(ifid_stall[k]),   32'(stl));
    expect_eq($sformatf("u%0d.ifid_flush", k), 32'(ifid_flush[k]),   32'(!stall_ext && ex_redirect));
  endtask

  task automatic check_zero(input int unsigned k, input string when);
    expect_eq($sformatf("%s.u%0d.ex", when, k),
              32'({ex_alu_src_b[k], ex_alu_op[k], ex_funct7_5[k], ex_branch[k], ex_b_type[k],
                   ex_rd[k], ex_illegal[k]}), 32'd0);
    expect_eq($sformatf("%s.u%0d.mem", when, k),
              32'({mem_mem_write[k], mem_rd[k], mem_reg_write[k]}), 32'd0);
    expect_eq($sformatf("%s.u%0d.wb", when, k),
              32'({wb_reg_write[k], wb_mem_to_reg[k], wb_rd[k]}), 32'd0);
    expect_eq($sformatf("%s.u%0d.haz", when, k),
              32'({pc_stall[k], ifid_stall[k], ifid_flush[k]}), 32'd0);
  endtask

  task automatic cyc();
    ctl_t nxt [2][3];
    @(negedge clk);
    for (int unsigned k = 0; k < 2; k++) begin
      check_all(k);
      nxt[k] = st[k];
      if (!stall_ext) begin
        nxt[k][2] = st[k][1];
        nxt[k][1] = st[k][0];
        nxt[k][0] = (ex_redirect || ref_load_use(st[k][0])) ? ctl_t'('0)
                  : ref_decode(op_code, funct3, funct7_5, rd, (k == 0));
      end
    end
    @(posedge clk);
    #1;
    st = nxt;
  endtask

  task automatic instr(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] d);
    op_code = opc; funct3 = f3; funct7_5 = 1'b0; rs1 = a; rs2 = b; rd = d;
  endtask

  task automatic model_reset();
    for (int unsigned k = 0; k < 2; k++)
      for (int unsigned s = 0; s < 3; s++) st[k][s] = '0;
  endtask

  logic [6:0] opcs [12];

  initial begin
    opcs = '{7'b0010011, 7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111,
             7'b1101111, 7'b1100111, 7'b0010111, 7'b1110011, 7'b1111111, 7'b0000011};
    rst_n = 1'b0; stall_ext = 1'b0; ex_redirect = 1'b0;
    instr(7'b0010011, 3'd0, 5'd0, 5'd0, 5'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero(0, "reset");
    check_zero(1, "reset");
    rst_n = 1'b1;

    // addi x1,x0,5 then idle
    instr(7'b0010011, 3'd0, 5'd0, 5'd0, 5'd1);
    cyc();
    expect_eq("t1.ex_src_b", 32'(ex_alu_src_b[0]), 32'd1);
    expect_eq("t1.ex_op", 32'(ex_alu_op[0]), 32'd0);
    instr(7'b0010011, 3'd0, 5'd0, 5'd0, 5'd0);
    cyc(); cyc();
    expect_eq("t1.wb", 32'({wb_reg_write[0], wb_rd[0], wb_mem_to_reg[0]}), 32'({1'b1, 5'd1, 2'b00}));

    // lw x2 then add x3,x2,x1
    instr(7'b0000011, 3'd2, 5'd1, 5'd0, 5'd2);
    cyc();
    instr(7'b0110011, 3'd0, 5'd2, 5'd1, 5'd3);
    #1;
    expect_eq("t2.stall", 32'({pc_stall[0], ifid_stall[0]}), 32'd3);
    cyc();
    expect_eq("t2.bubble_rd", 32'(ex_rd[0]), 32'd0);
    expect_eq("t2.mem_rd", 32'(mem_rd[0]), 32'd2);
    #1;
    expect_eq("t2.nostall", 32'(pc_stall[0]), 32'd0);
    cyc();
    expect_eq("t2.add_rd", 32'(ex_rd[0]), 32'd3);

    // redirect beats load-use
    instr(7'b0000011, 3'd2, 5'd1, 5'd0, 5'd2);
    cyc();
    instr(7'b0110011, 3'd0, 5'd2, 5'd2, 5'd4);
    ex_redirect = 1'b1;
    #1;
    expect_eq("t3.haz", 32'({pc_stall[0], ifid_flush[0]}), 32'b01);
    cyc();
    ex_redirect = 1'b0;
    expect_eq("t3.ex_rd", 32'(ex_rd[0]), 32'd0);
    expect_eq("t3.mem_rd", 32'(mem_rd[0]), 32'd2);

    // external stall for 3 cycles
    instr(7'b0010011, 3'd0, 5'd0, 5'd0, 5'd5);
    cyc();
    instr(7'b0010011, 3'd0, 5'd0, 5'd0, 5'd6);
    cyc();
    instr(7'b0010011, 3'd0, 5'd0, 5'd0, 5'd7);
    stall_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_eq("t4.hold", 32'({ex_rd[0], mem_rd[0]}), 32'({5'd6, 5'd5}));
    end
    stall_ext = 1'b0;
    cyc();
    expect_eq("t4.resume", 32'({ex_rd[0], mem_rd[0], wb_rd[0]}), 32'({5'd7, 5'd6, 5'd5}));

    // illegal opcode and CSR with/without CSR_EN
    instr(7'b1111111, 3'd7, 5'd1, 5'd1, 5'd9);
    funct7_5 = 1'b1;
    cyc();
    expect_eq("t5.ill", 32'({ex_illegal[0], ex_alu_src_b[0], ex_alu_op[0], ex_funct7_5[0], ex_rd[0]}),
              32'({1'b1, 1'b0, 4'd0, 1'b0, 5'd0}));
    instr(7'b1110011, 3'd1, 5'd0, 5'd0, 5'd7);
    cyc();
    expect_eq("t5.csr_en", 32'({ex_illegal[0], ex_rd[0]}), 32'({1'b0, 5'd7}));
    expect_eq("t5.csr_dis", 32'({ex_illegal[1], ex_rd[1]}), 32'({1'b1, 5'd0}));

    // reset during load-use stall
    instr(7'b0000011, 3'd2, 5'd1, 5'd0, 5'd2);
    cyc();
    instr(7'b0110011, 3'd0, 5'd3, 5'd2, 5'd3);
    #1;
    expect_eq("t6.stall", 32'(pc_stall[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero(0, "t6.rst");
    check_zero(1, "t6.rst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    instr(7'b0000011, 3'd2, 5'd1, 5'd0, 5'd0);
    cyc();
    instr(7'b0110011, 3'd0, 5'd0, 5'd0, 5'd3);
    #1;
    expect_eq("t6.x0_nostall", 32'(pc_stall[0]), 32'd0);
    cyc();

    // randomized stream
    for (int n = 0; n < 1500; n++) begin
      op_code     = opcs[$urandom_range(0, 11)];
      funct3      = 3'($urandom);
      funct7_5    = 1'($urandom);
      rs1         = 5'($urandom_range(0, 3));
      rs2         = 5'($urandom_range(0, 3));
      rd          = 5'($urandom_range(0, 3));
      stall_ext   = ($urandom_range(0, 9) == 0);
      ex_redirect = ($urandom_range(0, 6) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
